// File: rtl/freq_div_prog_if.sv
// freq_div_prog_if: control/status bundle for the programmable divider
// master: drives en, div_val, div_load; observes div_ack, new_clk, tick, cur_div
// slave:  the divider side of the same signals
interface freq_div_prog_if #(parameter int WIDTH = 8);
  logic             en;
  logic [WIDTH-1:0] div_val;
  logic             div_load;
  logic             div_ack;
  logic             new_clk;
  logic             tick;
  logic [WIDTH-1:0] cur_div;
  modport master(output en, div_val, div_load, input div_ack, new_clk, tick, cur_div);
  modport slave(input en, div_val, div_load, output div_ack, new_clk, tick, cur_div);
endinterface

// File: rtl/freq_div_prog.sv
// freq_div_prog: runtime-programmable divider producing a divided clock level and a period tick
// Ports: clk (system clock), rst (async, active low), bus (freq_div_prog_if.slave:
//   en, div_val, div_load in; div_ack, new_clk, tick, cur_div out)
// Option: define FREQ_DIV_ODD_HALF_EN for exact 50 % duty on odd divisors (adds a negedge stage)
module freq_div_prog #(
  parameter int WIDTH   = 8,
  parameter int DEF_DIV = 7
) (
  input logic            clk,
  input logic            rst,
  freq_div_prog_if.slave bus
);
  logic [WIDTH-1:0] cnt, cur_div, pend_val, load_val, nxt_div, half;
  logic             pend_vld, boundary, pos_q, tick_q, ack_q;
  always_comb begin
    load_val = (bus.div_val < WIDTH'(2)) ? WIDTH'(2) : bus.div_val;
    // a load arriving on the boundary cycle beats an older pending value
    nxt_div  = bus.div_load ? load_val : pend_val;
    boundary = bus.en && (cnt == cur_div - WIDTH'(1));
    half     = cur_div - (cur_div >> 1);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt      <= WIDTH'(DEF_DIV - 1);
      cur_div  <= WIDTH'(DEF_DIV);
      pend_val <= '0;
      pend_vld <= 1'b0;
      pos_q    <= 1'b0;
      tick_q   <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      tick_q <= boundary;
      ack_q  <= boundary && (bus.div_load || pend_vld);
      if (boundary) begin
        cnt   <= '0;
        pos_q <= 1'b1;
        if (bus.div_load || pend_vld) begin
          cur_div  <= nxt_div;
          pend_vld <= 1'b0;
        end
      end else begin
        if (bus.en) begin
          cnt   <= cnt + WIDTH'(1);
          pos_q <= (cnt + WIDTH'(1)) < half;
        end
        if (bus.div_load) begin
          pend_val <= load_val;
          pend_vld <= 1'b1;
        end
      end
    end
`ifdef FREQ_DIV_ODD_HALF_EN
  logic neg_q;
  // half-cycle delayed copy trims the high phase of odd divisors from ceil(D/2) to D/2
  always_ff @(negedge clk or negedge rst)
    if (!rst) neg_q <= 1'b0;
    else neg_q <= pos_q;
  assign bus.new_clk = cur_div[0] ? (pos_q & neg_q) : pos_q;
`else
  assign bus.new_clk = pos_q;
`endif
  assign bus.tick    = tick_q;
  assign bus.div_ack = ack_q;
  assign bus.cur_div = cur_div;
endmodule

// File: tb/tb_freq_div_prog.sv
// tb_freq_div_prog: scoreboard bench for freq_div_prog (expected ticks queued, monitor compares)
module tb_freq_div_prog;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  freq_div_prog_if #(.WIDTH(8)) bus();
  freq_div_prog #(.WIDTH(8), .DEF_DIV(7)) dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {int cyc; int ack; int div; int hi;} exp_t;
  exp_t q[$];
  function automatic int hi(int d);
`ifdef FREQ_DIV_ODD_HALF_EN
    return (d % 2 == 1) ? d / 2 : d - d / 2;
`else
    return d - d / 2;
`endif
  endfunction
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask
  task automatic exp_tick(int c, int a, int d, int h);
    exp_t e;
    e.cyc = c;
    e.ack = a;
    e.div = d;
    e.hi  = h;
    q.push_back(e);
  endtask
  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.en = 1'b0;
    bus.div_load = 1'b0;
    bus.div_val = '0;
    #1;
    chk("rst_new_clk", int'(bus.new_clk), 0);
    chk("rst_tick", int'(bus.tick), 0);
    chk("rst_div_ack", int'(bus.div_ack), 0);
    chk("rst_cur_div", int'(bus.cur_div), 7);
    step(2);
    rst = 1'b1;
    bus.en = 1'b1;
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    bus.en = 1'b0;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", q.size());
      q.delete();
    end
  endtask
  initial begin : monitor
    int   cyc = 0;
    int   hcnt = 0;
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        cyc  = 0;
        hcnt = 0;
      end else begin
        cyc++;
        if (bus.tick) begin
          if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_tick cycle=%0d expected=none", cyc);
          end else begin
            e = q.pop_front();
            chk("tick_cycle", cyc, e.cyc);
            chk("tick_ack", int'(bus.div_ack), e.ack);
            chk("tick_cur_div", int'(bus.cur_div), e.div);
            if (e.hi >= 0) chk("high_len", hcnt, e.hi);
          end
          hcnt = 0;
        end else if (bus.div_ack) begin
          checks++;
          failures++;
          $display("FAIL ack_without_tick cycle=%0d ack=1 expected=0", cyc);
        end
        if (bus.new_clk) hcnt++;
      end
    end
  end
  initial begin
    bus.en = 1'b0;
    bus.div_load = 1'b0;
    bus.div_val = '0;
    // free-running D=7
    do_reset();
    exp_tick(1, 0, 7, -1);
    exp_tick(8, 0, 7, hi(7));
    exp_tick(15, 0, 7, hi(7));
    exp_tick(22, 0, 7, hi(7));
    drain();
    // load 4 mid-period: old period completes, then D=4
    do_reset();
    exp_tick(1, 0, 7, -1);
    exp_tick(8, 1, 4, hi(7));
    exp_tick(12, 0, 4, hi(4));
    exp_tick(16, 0, 4, hi(4));
    step(3);
    bus.div_val = 8'd4;
    bus.div_load = 1'b1;
    step(1);
    bus.div_load = 1'b0;
    drain();
    // 9 then 3 in one period, then clamped loads of 0 and 1 (the latter on a boundary)
    do_reset();
    exp_tick(1, 0, 7, -1);
    exp_tick(8, 1, 3, hi(7));
    exp_tick(11, 0, 3, hi(3));
    exp_tick(14, 0, 3, hi(3));
    exp_tick(17, 1, 2, hi(3));
    exp_tick(19, 0, 2, hi(2));
    exp_tick(21, 0, 2, hi(2));
    exp_tick(23, 1, 2, hi(2));
    exp_tick(25, 0, 2, hi(2));
    step(2);
    bus.div_val = 8'd9;
    bus.div_load = 1'b1;
    step(1);
    bus.div_load = 1'b0;
    step(1);
    bus.div_val = 8'd3;
    bus.div_load = 1'b1;
    step(1);
    bus.div_load = 1'b0;
    step(10);
    bus.div_val = 8'd0;
    bus.div_load = 1'b1;
    step(1);
    bus.div_load = 1'b0;
    step(6);
    bus.div_val = 8'd1;
    bus.div_load = 1'b1;
    step(1);
    bus.div_load = 1'b0;
    drain();
    // en low for 5 cycles in the high phase, with a load of 5 captured while frozen
    do_reset();
    exp_tick(1, 0, 7, -1);
    exp_tick(13, 1, 5, hi(7) + 5);
    exp_tick(18, 0, 5, hi(5));
    exp_tick(23, 0, 5, hi(5));
    step(2);
    bus.en = 1'b0;
    step(1);
    bus.div_val = 8'd5;
    bus.div_load = 1'b1;
    step(1);
    bus.div_load = 1'b0;
    chk("freeze_new_clk", int'(bus.new_clk), 1);
    chk("freeze_tick", int'(bus.tick), 0);
    chk("freeze_cur_div", int'(bus.cur_div), 7);
    step(3);
    bus.en = 1'b1;
    drain();
    // reset in the high phase discards a pending load
    do_reset();
    exp_tick(1, 0, 7, -1);
    step(1);
    bus.div_val = 8'd3;
    bus.div_load = 1'b1;
    step(1);
    bus.div_load = 1'b0;
    chk("pre_rst_new_clk", int'(bus.new_clk), 1);
    chk("pre_rst_queue", q.size(), 0);
    do_reset();
    exp_tick(1, 0, 7, -1);
    exp_tick(8, 0, 7, hi(7));
    exp_tick(15, 0, 7, hi(7));
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/freq_div_prog.md
# freq_div_prog

Runtime-programmable clock-enable style frequency divider, successor to the fixed-N `freq_div`. It divides `clk` by a divisor that can be reloaded on the fly without glitches, and emits both a divided clock level (`new_clk`) and a one-cycle period strobe (`tick`). Divisor changes are queued and applied only at a period boundary, with a completion acknowledge. It sits in the clocking/timing section, feeding baud, PWM and sample-rate logic.

## Interface
- `WIDTH`, 8, width of divisor and internal counter.
- `DEF_DIV`, 7, divisor after reset; must satisfy 2 ≤ DEF_DIV ≤ 2^WIDTH−1.
- `clk`  in  1  system clock; all state on rising edge (except macro path, see Configuration).
- `rst`  in  1  asynchronous, active-low reset (asserted when 0).
- `en`  in  1  count enable; low freezes the divider.
- `div_val`  in  WIDTH  requested divisor.
- `div_load`  in  1  one-cycle request to queue `div_val`.
- `div_ack`  out  1  one-cycle pulse: the queued divisor has taken effect.
- `new_clk`  out  1  divided clock, registered.
- `tick`  out  1  one-cycle pulse aligned with every rising edge of `new_clk`.
- `cur_div`  out  WIDTH  divisor currently in effect.

## Operation
- State: `cnt` (WIDTH), `cur_div`, `pend_val`, `pend_vld`.
- Divisor D = `cur_div`; high-phase length H = ceil(D/2) = D − floor(D/2). Period D cycles: high H, low D−H (D=7: 4/3; D=2: 1/1).
- Queue: `div_load`=1 captures `div_val` into `pend_val`, sets `pend_vld`. Values 0 and 1 are clamped to 2 on capture. A later load before application overwrites the earlier one (last wins, single `div_ack`).
- Enabled edge, `cnt` = D−1 (boundary): `cnt`←0; if `pend_vld` (including a load on this same cycle, which takes priority over an older pending value) then `cur_div`←pending value, `pend_vld`←0, `div_ack`←1; `new_clk`←1; `tick`←1. H for the new period is computed from the new divisor.
- Enabled edge, otherwise: `cnt`←`cnt`+1; `new_clk`←(`cnt`+1 < H); `tick`←0; `div_ack`←0.
- `en`=0: `cnt`, `new_clk`, `cur_div` hold; `tick`=`div_ack`=0 on the next edge; loads still captured but applied only at the next enabled boundary.
- No other state machine; the counter is the sole sequencer. Counter never exceeds D−1, so no wrap beyond the boundary is possible.

## Timing
- Reset values: `cnt`=DEF_DIV−1, `cur_div`=DEF_DIV, `pend_vld`=0, `new_clk`=0, `tick`=0, `div_ack`=0.
- First enabled edge after reset release is a boundary: `new_clk` and `tick` rise 1 cycle after `en`=1 with `rst`=1.
- `new_clk` and `tick` change only on `clk` rising edge; no combinational path from any input to any output.
- Load latency: `div_ack` and the new `cur_div` appear on the edge that ends the current period, i.e. between 1 and D_old cycles after the load; the in-flight period always completes at D_old.
- Reset asserted mid-period forces reset values immediately (asynchronous); any pending divisor is discarded.

## Configuration
- `FREQ_DIV_ODD_HALF_EN` defined: for odd D, `new_clk` has exact 50 % duty. A second register samples the posedge-generated high phase on falling `clk`; `new_clk` = posedge_phase AND negedge_copy, giving a high time of D/2 clock periods. Even D unchanged. `tick` remains posedge-registered and unchanged. Negedge register resets to 0.
- Not defined: no negedge logic; odd D gives ceil(D/2)/floor(D/2) duty as above.

## Test plan
- Reset, `en`=1, no loads, 10 ns clk: `new_clk` period 70 ns, high 40 ns, `tick` every 7 cycles, `cur_div`=7.
- `div_load` with `div_val`=4 at `cnt`=2: period ends at 7 cycles, `div_ack` pulses once, then 2 high/2 low; `cur_div`=4.
- Two loads (9 then 3) in one period: single `div_ack`, `cur_div`=3, 2 high/1 low afterwards; `div_val`=0 or 1 load → `cur_div`=2, 1/1 toggling.
- `en` dropped for 5 cycles mid-high-phase: `new_clk` holds 1, no `tick`, remaining high cycles resume exactly after `en` returns.
- `rst` pulsed low mid-period with a pending load: outputs 0 immediately, `cur_div`=7 after release, pending value never applied.
- With `FREQ_DIV_ODD_HALF_EN`, D=5: `new_clk` high 25 ns, low 25 ns; D=4: 20/20 ns.
